move_validator: RTL and testbench

- Datapath responder for the game controller's move-check request: on `check_en` it scans the board around the cursor in all 8 directions.
- It returns `valid_move`, an 8-bit flip-direction mask and a one-cycle `go` (done) pulse.
- It reads board state through a synchronous single-read port of the board RAM and sits between the controller and the place/flip engines, which consume `dir_mask`.

---
 rtl/reversi_pkg.sv | 26 ++
 rtl/move_validator_if.sv | 24 ++
 rtl/reversi_dir_step.sv | 30 +++
 rtl/move_validator.sv | 154 +++++++++++++++
 tb/tb_move_validator.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell encodings, board size and direction step tables.
package reversi_pkg;

   localparam int unsigned BOARD_DIM = 8;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_BLACK = 2'b01;
   localparam logic [1:0] CELL_WHITE = 2'b10;

   typedef enum logic [2:0] {
      DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
   } dirE;

   // Indexed by direction; y grows downwards (N is -1).
   localparam logic signed [3:0] DIR_DX [8] = '{
      4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1
   };
   localparam logic signed [3:0] DIR_DY [8] = '{
      -4'sd1, -4'sd1, 4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1
   };

   function automatic logic [1:0] opponent_code(input logic player);
      return player ? CELL_BLACK : CELL_WHITE;
   endfunction

endpackage

// File: rtl/move_validator_if.sv
// Controller/board-RAM signal bundle for the move validator.
interface move_validator_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              check_en;
   logic [2:0]        cursor_x;
   logic [2:0]        cursor_y;
   logic              player;
   logic [ADDR_W-1:0] board_addr;
   logic [1:0]        board_data;
   logic              go;
   logic              valid_move;
   logic [7:0]        dir_mask;

   modport master (
      output check_en, cursor_x, cursor_y, player, board_data,
      input  board_addr, go, valid_move, dir_mask
   );

   modport slave (
      input  check_en, cursor_x, cursor_y, player, board_data,
      output board_addr, go, valid_move, dir_mask
   );
endinterface

// File: rtl/reversi_dir_step.sv
// One step along a direction; works in 5-bit signed so that -1 and BOARD_DIM are both visible.
module reversi_dir_step #(
   parameter int unsigned BOARD_DIM = 8
) (
   input  logic signed [3:0] pos_x,
   input  logic signed [3:0] pos_y,
   input  logic [2:0]        d,
   output logic signed [3:0] next_x,
   output logic signed [3:0] next_y,
   output logic              off_board
);
   import reversi_pkg::DIR_DX;
   import reversi_pkg::DIR_DY;

   localparam logic signed [4:0] DIM_S = 5'(BOARD_DIM);

   logic signed [3:0] dx, dy;
   logic signed [4:0] wideX, wideY;

   always_comb begin
      dx        = DIR_DX[d];
      dy        = DIR_DY[d];
      wideX     = $signed({pos_x[3], pos_x}) + $signed({dx[3], dx});
      wideY     = $signed({pos_y[3], pos_y}) + $signed({dy[3], dy});
      next_x    = wideX[3:0];
      next_y    = wideY[3:0];
      off_board = (wideX < 5'sd0) || (wideX >= DIM_S) ||
                  (wideY < 5'sd0) || (wideY >= DIM_S);
   end
endmodule

// File: rtl/move_validator.sv
// Move-check responder: scans the 8 rays from the cursor through a synchronous board RAM
// and reports which directions capture, with a one-cycle go pulse on completion.
module move_validator #(
   parameter int unsigned BOARD_DIM = 8,
   parameter int unsigned ADDR_W    = 6
) (
   input  logic             clk,
   input  logic             resetn,
   move_validator_if.slave  bus
);
   import reversi_pkg::CELL_BLACK;
   import reversi_pkg::CELL_WHITE;
   import reversi_pkg::DIR_NW;
   import reversi_pkg::opponent_code;

   typedef enum logic [2:0] {
      IDLE, RD_TARGET, EVAL_TARGET, DIR_STEP, DIR_EVAL, NEXT_DIR, DONE, RELEASE
   } stateE;

   stateE             state;
   logic [2:0]        curX, curY;
   logic              playerQ;
   logic signed [3:0] posX, posY;
   logic [2:0]        dirIdx;
   logic [2:0]        runLen;
   logic [7:0]        scratch;
   logic              firstStep;
   logic              goQ, validQ;
   logic [7:0]        maskQ;

   logic signed [3:0] baseX, baseY, nextX, nextY;
   logic              offBoard;
   logic [1:0]        ownCode, oppCode;
   logic [5:0]        addrCell;

   assign baseX   = firstStep ? $signed({1'b0, curX}) : posX;
   assign baseY   = firstStep ? $signed({1'b0, curY}) : posY;
   assign ownCode = playerQ ? CELL_WHITE : CELL_BLACK;
   assign oppCode = opponent_code(playerQ);

   reversi_dir_step #(.BOARD_DIM(BOARD_DIM)) stepper (
      .pos_x     (baseX),
      .pos_y     (baseY),
      .d         (dirIdx),
      .next_x    (nextX),
      .next_y    (nextY),
      .off_board (offBoard)
   );

   // The step target is presented during DIR_STEP so its data lands in DIR_EVAL;
   // otherwise the registered position keeps the last presented address.
   always_comb begin
      addrCell = {posY[2:0], posX[2:0]};
      if (state == DIR_STEP && !offBoard)
         addrCell = {nextY[2:0], nextX[2:0]};
   end

   assign bus.board_addr = ADDR_W'(addrCell);
   assign bus.go         = goQ;
   assign bus.valid_move = validQ;
   assign bus.dir_mask   = maskQ;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         curX      <= '0;
         curY      <= '0;
         playerQ   <= 1'b0;
         posX      <= '0;
         posY      <= '0;
         dirIdx    <= '0;
         runLen    <= '0;
         scratch   <= '0;
         firstStep <= 1'b0;
         goQ       <= 1'b0;
         validQ    <= 1'b0;
         maskQ     <= '0;
      end else begin
         goQ <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.check_en) begin
                  curX    <= bus.cursor_x;
                  curY    <= bus.cursor_y;
                  playerQ <= bus.player;
                  posX    <= $signed({1'b0, bus.cursor_x});
                  posY    <= $signed({1'b0, bus.cursor_y});
                  scratch <= '0;
                  state   <= RD_TARGET;
               end
            end
            RD_TARGET: state <= bus.check_en ? EVAL_TARGET : IDLE;
            EVAL_TARGET: begin
               if (!bus.check_en) begin
                  state <= IDLE;
               end else if (bus.board_data == CELL_BLACK || bus.board_data == CELL_WHITE) begin
                  maskQ  <= '0;
                  validQ <= 1'b0;
                  goQ    <= 1'b1;
                  state  <= DONE;
               end else begin
                  dirIdx    <= '0;
                  firstStep <= 1'b1;
                  state     <= DIR_STEP;
               end
            end
            DIR_STEP: begin
               if (!bus.check_en) begin
                  state <= IDLE;
               end else begin
                  firstStep <= 1'b0;
                  if (firstStep) runLen <= '0;
                  if (offBoard) begin
                     state <= NEXT_DIR;
                  end else begin
                     posX  <= nextX;
                     posY  <= nextY;
                     state <= DIR_EVAL;
                  end
               end
            end
            DIR_EVAL: begin
               if (!bus.check_en) begin
                  state <= IDLE;
               end else if (bus.board_data == oppCode) begin
                  runLen <= runLen + 3'd1;
                  state  <= DIR_STEP;
               end else begin
                  if (bus.board_data == ownCode && runLen != 3'd0)
                     scratch[dirIdx] <= 1'b1;
                  state <= NEXT_DIR;
               end
            end
            NEXT_DIR: begin
               if (!bus.check_en) begin
                  state <= IDLE;
               end else if (dirIdx == DIR_NW) begin
                  maskQ  <= scratch;
                  validQ <= |scratch;
                  goQ    <= 1'b1;
                  state  <= DONE;
               end else begin
                  dirIdx    <= dirIdx + 3'd1;
                  firstStep <= 1'b1;
                  state     <= DIR_STEP;
               end
            end
            DONE:    state <= RELEASE;
            RELEASE: if (!bus.check_en) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_move_validator.sv
// Directed bench for move_validator with a behavioural synchronous board RAM.
module tb_move_validator;
   import reversi_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   move_validator_if #(.ADDR_W(6)) bus ();

   move_validator #(.BOARD_DIM(8), .ADDR_W(6)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   logic [1:0] board [64];
   always @(posedge clk) bus.board_data <= board[bus.board_addr];

   int goCount = 0;
   always @(posedge clk) if (bus.go === 1'b1) goCount++;

   int testsRun = 0;
   int testsFailed = 0;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearBoard();
      for (int i = 0; i < 64; i++) board[i] = CELL_EMPTY;
   endtask

   task automatic setCell(input int x, input int y, input logic [1:0] v);
      board[y*8 + x] = v;
   endtask

   task automatic startReq(input int x, input int y, input logic p);
      bus.cursor_x = 3'(x);
      bus.cursor_y = 3'(y);
      bus.player   = p;
      bus.check_en = 1'b1;
   endtask

   // Holds check_en well past go to confirm RELEASE never retriggers.
   task automatic runCheck(input string tag, input int x, input int y, input logic p,
                           output int lat, output logic [5:0] firstAddr);
      int startGo;
      startGo   = goCount;
      lat       = 0;
      firstAddr = '0;
      @(negedge clk);
      startReq(x, y, p);
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (i == 1) firstAddr = bus.board_addr;
         if (bus.go === 1'b1) begin
            lat = i;
            break;
         end
      end
      checkVal({tag, "GoSeen"}, 32'(lat != 0), 1);
      repeat (8) @(negedge clk);
      checkVal({tag, "GoOnce"}, 32'(goCount - startGo), 1);
      bus.check_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic setOpening();
      clearBoard();
      setCell(3, 3, CELL_WHITE);
      setCell(4, 4, CELL_WHITE);
      setCell(4, 3, CELL_BLACK);
      setCell(3, 4, CELL_BLACK);
   endtask

   task automatic setTriple();
      clearBoard();
      setCell(3, 2, CELL_WHITE);
      setCell(2, 3, CELL_WHITE);
      setCell(3, 3, CELL_WHITE);
      setCell(4, 2, CELL_BLACK);
      setCell(2, 4, CELL_BLACK);
      setCell(4, 4, CELL_BLACK);
   endtask

   task automatic abortScan(input string tag, input int cycles,
                            input logic [7:0] keepMask, input logic keepValid);
      int startGo;
      startGo = goCount;
      @(negedge clk);
      startReq(2, 2, 1'b0);
      repeat (cycles) @(negedge clk);
      bus.check_en = 1'b0;
      repeat (3) @(negedge clk);
      checkVal({tag, "NoGo"}, 32'(goCount - startGo), 0);
      checkVal({tag, "Mask"}, 32'(bus.dir_mask), 32'(keepMask));
      checkVal({tag, "Valid"}, 32'(bus.valid_move), 32'(keepValid));
   endtask

   int lat;
   logic [5:0] addr0;

   initial begin
      bus.check_en = 1'b0;
      bus.cursor_x = '0;
      bus.cursor_y = '0;
      bus.player   = 1'b0;
      clearBoard();
      repeat (2) @(negedge clk);
      checkVal("rstGo", 32'(bus.go), 0);
      checkVal("rstValid", 32'(bus.valid_move), 0);
      checkVal("rstMask", 32'(bus.dir_mask), 0);
      checkVal("rstAddr", 32'(bus.board_addr), 0);
      resetn = 1'b1;
      @(negedge clk);

      // Opening position, black to move at (3,2): only S captures.
      setOpening();
      runCheck("t1", 3, 2, 1'b0, lat, addr0);
      checkVal("t1Addr", 32'(addr0), 19);
      checkVal("t1LatBound", 32'(lat <= 130), 1);
      checkVal("t1Valid", 32'(bus.valid_move), 1);
      checkVal("t1Mask", 32'(bus.dir_mask), 32'h10);

      // Occupied target rejects early.
      runCheck("t2", 3, 3, 1'b0, lat, addr0);
      checkVal("t2Lat", 32'(lat), 3);
      checkVal("t2Addr", 32'(addr0), 27);
      checkVal("t2Valid", 32'(bus.valid_move), 0);
      checkVal("t2Mask", 32'(bus.dir_mask), 0);

      // White run to the east edge never closes.
      clearBoard();
      for (int x = 1; x < 8; x++) setCell(x, 0, CELL_WHITE);
      runCheck("t3", 0, 0, 1'b0, lat, addr0);
      checkVal("t3LatBound", 32'(lat <= 130), 1);
      checkVal("t3Valid", 32'(bus.valid_move), 0);
      checkVal("t3Mask", 32'(bus.dir_mask), 0);

      // Abort mid-scan on the triple-capture board keeps the previous result.
      setTriple();
      abortScan("t5", 10, 8'h00, 1'b0);

      runCheck("t4", 2, 2, 1'b0, lat, addr0);
      checkVal("t4LatBound", 32'(lat <= 130), 1);
      checkVal("t4Valid", 32'(bus.valid_move), 1);
      checkVal("t4Mask", 32'(bus.dir_mask), 32'h1C);

      // Late abort (deep in the scan) must also leave 0x1C untouched.
      abortScan("t5b", 30, 8'h1C, 1'b1);

      // Asynchronous reset mid-scan clears everything at once.
      @(negedge clk);
      startReq(2, 2, 1'b0);
      repeat (8) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      checkVal("t6RstGo", 32'(bus.go), 0);
      checkVal("t6RstValid", 32'(bus.valid_move), 0);
      checkVal("t6RstMask", 32'(bus.dir_mask), 0);
      checkVal("t6RstAddr", 32'(bus.board_addr), 0);
      bus.check_en = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Fresh request after reset with check_en held through DONE.
      runCheck("t6", 2, 2, 1'b0, lat, addr0);
      checkVal("t6Mask", 32'(bus.dir_mask), 32'h1C);
      checkVal("t6Valid", 32'(bus.valid_move), 1);

      // White to move on the opening board at (4,2): S via (4,3) black to (4,4) white.
      setOpening();
      runCheck("t7", 4, 2, 1'b1, lat, addr0);
      checkVal("t7Mask", 32'(bus.dir_mask), 32'h10);
      checkVal("t7Valid", 32'(bus.valid_move), 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
